digit_serial_addsub: RTL



---
 rtl/digit_serial_addsub.sv | 112 +++++++++++
 1 files changed

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : digit_serial_addsub
// Brief   : Multi-cycle add/subtract, DIGIT bits per clock via a carry register.
// Revision: 1.0
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic [DIGIT:0]   dsum;
    logic             msb_cin_d;
    logic             ovf_d;

    // Operands shift right each step, so the active digit is always the low one.
    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

    // On the last step the digit's top bit is the word MSB; recover its carry-in.
    assign msb_cin_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    assign ovf_d     = msb_cin_d ^ dsum[DIGIT];

    assign res_d = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? ~c_in : c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= dsum[DIGIT];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        s_q     <= res_d;
                        c_out_q <= dsum[DIGIT];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire
